// File: rtl/wb_spiflash_responder_pkg.sv
// Shared constants and state encodings for the SPI flash responder.
package spiflash_pkg;

  localparam int ADDR_W = 24;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_RDP  = 8'hAB;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_IGNORE
  } main_state_t;

  typedef enum logic {
    W_IDLE,
    W_REQ
  } wb_state_t;

endpackage

// File: rtl/wb_spiflash_responder_if.sv
// Wishbone read-only bus between the responder (master) and the backing memory.
interface wb_spiflash_responder_if;
  import spiflash_pkg::*;

  logic [ADDR_W-1:0] wb_adr_o;
  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic [31:0]       wb_dat_i;
  logic              wb_ack_i;

  modport master (
    output wb_adr_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i
  );

endinterface

// File: rtl/spi_edge_sync.sv
// Two-flop synchronizer for one SPI pin plus a third register for edge pulses.
module spi_edge_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_sr;

  // Reset to the pin's idle level so leaving reset never fakes an edge.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) sync_sr <= {3{RESET_VAL}};
    else          sync_sr <= {sync_sr[1:0], din};
  end

  assign level = sync_sr[1];
  assign rise  = sync_sr[1] & ~sync_sr[2];
  assign fall  = ~sync_sr[1] & sync_sr[2];

endmodule

// File: rtl/wb_spiflash_responder.sv
// Serial-NOR read responder: decodes 0x03 reads on SPI mode 3 and serves the
// bytes from a Wishbone memory, everything clocked by wb_clk_i.
module wb_spiflash_responder
  import spiflash_pkg::*;
#(
  parameter int SCLK_MIN_HALF = 4
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic spi_cs,
  input  logic spi_sclk,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic underrun,
  wb_spiflash_responder_if.master wb
);

  localparam int PIN_LATENCY = 4;

  if (SCLK_MIN_HALF < PIN_LATENCY) begin : g_half_check
    $error("SCLK_MIN_HALF shorter than SCLK-to-MISO latency");
  end

  logic cs_level, cs_rise, cs_fall;
  logic sclk_level, sclk_rise, sclk_fall;
  logic mosi_level, mosi_rise, mosi_fall;

  spi_edge_sync #(.RESET_VAL(1'b1)) u_cs (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .din(spi_cs),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall));

  spi_edge_sync #(.RESET_VAL(1'b1)) u_sclk (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .din(spi_sclk),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall));

  spi_edge_sync #(.RESET_VAL(1'b0)) u_mosi (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .din(spi_mosi),
    .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall));

  logic unused_edges;
  assign unused_edges = cs_rise ^ sclk_level ^ mosi_rise ^ mosi_fall;

  main_state_t state, state_next;
  wb_state_t   wb_state, wb_next;

  logic [4:0]        bit_cnt;
  logic [20:0]       rx_sr;
  logic [7:0]        tx_sr;
  logic [1:0]        ptr;
  logic [ADDR_W-3:0] word_adr;
  logic              req_pend;
  logic              valid;
  logic              stale;
  logic [31:0]       data_q;
  logic [7:0]        opcode;
  logic [7:0]        cur_byte;
  logic              wb_take;
  logic              wb_done;

  assign opcode   = {rx_sr[6:0], mosi_level};
  assign cur_byte = valid ? data_q[{ptr, 3'b000} +: 8] : 8'hFF;
  assign wb_take  = (wb_state == W_IDLE) && req_pend && !cs_level;
  assign wb_done  = (wb_state == W_REQ) && wb.wb_ack_i;

  assign wb.wb_cyc_o = (wb_state == W_REQ);
  assign wb.wb_stb_o = wb.wb_cyc_o;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= S_IDLE;
      wb_state <= W_IDLE;
    end else begin
      state    <= state_next;
      wb_state <= wb_next;
    end
  end

  // A deasserted chip select overrides every state, discarding partial bits.
  always_comb begin
    state_next = state;
    if (cs_level) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (cs_fall) state_next = S_CMD;
        S_CMD:
          if (sclk_rise && bit_cnt == 5'd7) begin
            case (opcode)
              OP_READ: state_next = S_ADDR;
              OP_RDP:  state_next = S_IGNORE;
              default: state_next = S_IGNORE;
            endcase
          end
        S_ADDR: if (sclk_rise && bit_cnt == 5'd23) state_next = S_DATA;
        default: state_next = state;
      endcase
    end
  end

  always_comb begin
    wb_next = wb_state;
    case (wb_state)
      W_IDLE:  if (wb_take) wb_next = W_REQ;
      W_REQ:   if (wb.wb_ack_i) wb_next = W_IDLE;
      default: wb_next = W_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      bit_cnt     <= '0;
      rx_sr       <= '0;
      tx_sr       <= '1;
      ptr         <= '0;
      word_adr    <= '0;
      req_pend    <= 1'b0;
      valid       <= 1'b0;
      stale       <= 1'b0;
      data_q      <= '0;
      spi_miso    <= 1'b1;
      underrun    <= 1'b0;
      wb.wb_adr_o <= '0;
    end else begin
      underrun <= 1'b0;
      if (wb_take) begin
        wb.wb_adr_o <= {word_adr, 2'b00};
        req_pend    <= 1'b0;
      end
      if (wb_done) begin
        data_q <= wb.wb_dat_i;
        valid  <= !stale;
        stale  <= 1'b0;
      end
      // A request still in flight when CS rises must complete, but its word is dropped.
      if (cs_level) begin
        bit_cnt  <= '0;
        spi_miso <= 1'b1;
        valid    <= 1'b0;
        req_pend <= 1'b0;
        if (wb_state == W_REQ && !wb.wb_ack_i) stale <= 1'b1;
      end else begin
        case (state)
          S_CMD, S_ADDR:
            if (sclk_rise) begin
              rx_sr   <= {rx_sr[19:0], mosi_level};
              bit_cnt <= bit_cnt + 5'd1;
              if (state == S_CMD && bit_cnt == 5'd7) bit_cnt <= '0;
              if (state == S_ADDR && bit_cnt == 5'd21) begin
                word_adr <= {rx_sr[20:0], mosi_level};
                req_pend <= 1'b1;
              end
              if (state == S_ADDR && bit_cnt == 5'd23) begin
                ptr     <= {rx_sr[0], mosi_level};
                bit_cnt <= '0;
              end
            end
          S_DATA:
            if (sclk_fall) begin
              if (bit_cnt == 5'd0) begin
                spi_miso <= cur_byte[7];
                tx_sr    <= {cur_byte[6:0], 1'b1};
                bit_cnt  <= 5'd1;
                ptr      <= ptr + 2'd1;
                if (!valid) underrun <= 1'b1;
                // Last byte of the word is going out: fetch the following word now.
                if (ptr == 2'd3) begin
                  valid    <= 1'b0;
                  word_adr <= word_adr + 1'b1;
                  req_pend <= 1'b1;
                end
              end else begin
                spi_miso <= tx_sr[7];
                tx_sr    <= {tx_sr[6:0], 1'b1};
                bit_cnt  <= (bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
              end
            end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_spiflash_responder.sv
// Directed bench: SPI mode-3 master (half-period 4) against a Wishbone memory model.
module tb_wb_spiflash_responder;
  import spiflash_pkg::*;

  localparam int HALF = 4;

  logic wb_clk_i = 1'b0;
  logic wb_rst_i = 1'b1;
  logic spi_cs   = 1'b1;
  logic spi_sclk = 1'b1;
  logic spi_mosi = 1'b0;
  logic spi_miso;
  logic underrun;

  wb_spiflash_responder_if bus();

  wb_spiflash_responder #(.SCLK_MIN_HALF(HALF)) dut (
    .wb_clk_i(wb_clk_i),
    .wb_rst_i(wb_rst_i),
    .spi_cs(spi_cs),
    .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .underrun(underrun),
    .wb(bus)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int          ack_lat = 2;
  int          ack_cnt = 0;
  int          underrun_cnt = 0;
  bit          miso_low_seen = 1'b0;
  logic        cyc_prev = 1'b0;
  logic [23:0] req_log [$];
  logic [7:0]  rx_buf [8];
  int          pass_cnt = 0;
  int          check_cnt = 0;

  function automatic logic [31:0] mem_word(input logic [23:0] a);
    case (a)
      24'h000000: return 32'h04030201;
      24'h000004: return 32'h44332211;
      24'h000008: return 32'h88776655;
      24'hFFFFFC: return 32'hDDCCBBAA;
      default:    return 32'hA5A5A5A5;
    endcase
  endfunction

  // Memory responder with programmable ack latency, plus event logging.
  always @(posedge wb_clk_i) begin
    cyc_prev <= bus.wb_cyc_o;
    if (bus.wb_cyc_o === 1'b1 && cyc_prev === 1'b0) req_log.push_back(bus.wb_adr_o);
    if (underrun === 1'b1) underrun_cnt++;
    if (spi_miso !== 1'b1) miso_low_seen = 1'b1;
    if (wb_rst_i || bus.wb_cyc_o !== 1'b1) begin
      ack_cnt = 0;
      bus.wb_ack_i <= 1'b0;
      bus.wb_dat_i <= '0;
    end else if (bus.wb_ack_i) begin
      bus.wb_ack_i <= 1'b0;
    end else if (ack_cnt >= ack_lat - 1) begin
      bus.wb_ack_i <= 1'b1;
      bus.wb_dat_i <= mem_word(bus.wb_adr_o);
      ack_cnt = 0;
    end else begin
      ack_cnt++;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic spi_wait(input int n);
    repeat (n) @(negedge wb_clk_i);
  endtask

  task automatic spi_bit(input logic b, output logic r);
    spi_sclk = 1'b0;
    spi_mosi = b;
    spi_wait(HALF);
    spi_sclk = 1'b1;
    r = spi_miso;
    spi_wait(HALF);
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) spi_bit(tx[i], rx[i]);
  endtask

  task automatic spi_begin();
    spi_cs = 1'b0;
    spi_wait(HALF);
  endtask

  task automatic spi_end();
    spi_cs = 1'b1;
    spi_wait(8);
  endtask

  task automatic spi_read(input logic [7:0] op, input logic [23:0] adr, input int n);
    logic [7:0] r;
    spi_begin();
    spi_byte(op, r);
    spi_byte(adr[23:16], r);
    spi_byte(adr[15:8], r);
    spi_byte(adr[7:0], r);
    for (int i = 0; i < n; i++) begin
      spi_byte(8'h00, r);
      rx_buf[i] = r;
    end
    spi_end();
  endtask

  task automatic clear_logs();
    req_log.delete();
    underrun_cnt  = 0;
    miso_low_seen = 1'b0;
  endtask

  function automatic logic [23:0] req_at(input int i);
    return (req_log.size() > i) ? req_log[i] : 24'hxxxxxx;
  endfunction

  task automatic test_reset();
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i);
    for (int i = 0; i < 3; i++) begin
      @(negedge wb_clk_i);
      check_cnt++;
      if (spi_miso !== 1'b1) $display("[TB] FAIL reset_miso: got %b, expected 1", spi_miso);
      else pass_cnt++;
      check_cnt++;
      if (bus.wb_cyc_o !== 1'b0) $display("[TB] FAIL reset_cyc: got %b, expected 0", bus.wb_cyc_o);
      else pass_cnt++;
      check_cnt++;
      if (underrun !== 1'b0) $display("[TB] FAIL reset_underrun: got %b, expected 0", underrun);
      else pass_cnt++;
    end
    check_cnt++;
    if (bus.wb_adr_o !== 24'h0) $display("[TB] FAIL reset_adr: got %06h, expected 000000", bus.wb_adr_o);
    else pass_cnt++;
    wb_rst_i = 1'b0;
    spi_wait(4);
  endtask

  task automatic test_read_aligned();
    logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    clear_logs();
    spi_read(8'h03, 24'h000004, 4);
    for (int i = 0; i < 4; i++) begin
      check_cnt++;
      if (rx_buf[i] !== exp[i]) $display("[TB] FAIL aligned_byte%0d: got %02h, expected %02h", i, rx_buf[i], exp[i]);
      else pass_cnt++;
    end
    check_cnt++;
    if (req_log.size() != 2) $display("[TB] FAIL aligned_nreq: got %0d, expected 2", req_log.size());
    else pass_cnt++;
    check_cnt++;
    if (req_at(0) !== 24'h000004) $display("[TB] FAIL aligned_req0: got %06h, expected 000004", req_at(0));
    else pass_cnt++;
    check_cnt++;
    if (req_at(1) !== 24'h000008) $display("[TB] FAIL aligned_req1: got %06h, expected 000008", req_at(1));
    else pass_cnt++;
    check_cnt++;
    if (underrun_cnt != 0) $display("[TB] FAIL aligned_underrun: got %0d pulses, expected 0", underrun_cnt);
    else pass_cnt++;
  endtask

  task automatic test_read_unaligned();
    logic [7:0] exp [4] = '{8'h33, 8'h44, 8'h55, 8'h66};
    clear_logs();
    spi_read(8'h03, 24'h000006, 4);
    for (int i = 0; i < 4; i++) begin
      check_cnt++;
      if (rx_buf[i] !== exp[i]) $display("[TB] FAIL unaligned_byte%0d: got %02h, expected %02h", i, rx_buf[i], exp[i]);
      else pass_cnt++;
    end
    check_cnt++;
    if (req_at(0) !== 24'h000004) $display("[TB] FAIL unaligned_req0: got %06h, expected 000004", req_at(0));
    else pass_cnt++;
    check_cnt++;
    if (req_at(1) !== 24'h000008) $display("[TB] FAIL unaligned_req1: got %06h, expected 000008", req_at(1));
    else pass_cnt++;
  endtask

  task automatic test_read_wrap();
    logic [7:0] exp [8] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04};
    clear_logs();
    spi_read(8'h03, 24'hFFFFFC, 8);
    for (int i = 0; i < 8; i++) begin
      check_cnt++;
      if (rx_buf[i] !== exp[i]) $display("[TB] FAIL wrap_byte%0d: got %02h, expected %02h", i, rx_buf[i], exp[i]);
      else pass_cnt++;
    end
    check_cnt++;
    if (req_at(0) !== 24'hFFFFFC) $display("[TB] FAIL wrap_req0: got %06h, expected fffffc", req_at(0));
    else pass_cnt++;
    check_cnt++;
    if (req_at(1) !== 24'h000000) $display("[TB] FAIL wrap_req1: got %06h, expected 000000", req_at(1));
    else pass_cnt++;
    check_cnt++;
    if (underrun_cnt != 0) $display("[TB] FAIL wrap_underrun: got %0d pulses, expected 0", underrun_cnt);
    else pass_cnt++;
  endtask

  task automatic test_ignore_opcodes();
    logic [7:0] r;
    clear_logs();
    spi_begin();
    spi_byte(8'hAB, r);
    spi_end();
    check_cnt++;
    if (r !== 8'hFF) $display("[TB] FAIL rdp_miso: got %02h, expected ff", r);
    else pass_cnt++;
    check_cnt++;
    if (dut.state !== S_IDLE) $display("[TB] FAIL rdp_idle: got state %0d, expected %0d", dut.state, S_IDLE);
    else pass_cnt++;
    spi_read(8'h5A, 24'h000000, 1);
    check_cnt++;
    if (rx_buf[0] !== 8'hFF) $display("[TB] FAIL unknown_op_data: got %02h, expected ff", rx_buf[0]);
    else pass_cnt++;
    check_cnt++;
    if (dut.state !== S_IDLE) $display("[TB] FAIL unknown_op_idle: got state %0d, expected %0d", dut.state, S_IDLE);
    else pass_cnt++;
    check_cnt++;
    if (req_log.size() != 0) $display("[TB] FAIL ignore_nreq: got %0d, expected 0", req_log.size());
    else pass_cnt++;
    check_cnt++;
    if (miso_low_seen) $display("[TB] FAIL ignore_miso_low: got low MISO, expected constant 1");
    else pass_cnt++;
  endtask

  task automatic test_abort_addr();
    logic [7:0] r;
    logic       b;
    logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    clear_logs();
    spi_begin();
    spi_byte(8'h03, r);
    for (int i = 0; i < 10; i++) spi_bit(1'b1, b);
    spi_end();
    check_cnt++;
    if (req_log.size() != 0) $display("[TB] FAIL abort_nreq: got %0d, expected 0", req_log.size());
    else pass_cnt++;
    check_cnt++;
    if (dut.state !== S_IDLE) $display("[TB] FAIL abort_idle: got state %0d, expected %0d", dut.state, S_IDLE);
    else pass_cnt++;
    spi_read(8'h03, 24'h000004, 4);
    for (int i = 0; i < 4; i++) begin
      check_cnt++;
      if (rx_buf[i] !== exp[i]) $display("[TB] FAIL abort_then_byte%0d: got %02h, expected %02h", i, rx_buf[i], exp[i]);
      else pass_cnt++;
    end
    check_cnt++;
    if (req_at(0) !== 24'h000004) $display("[TB] FAIL abort_then_req0: got %06h, expected 000004", req_at(0));
    else pass_cnt++;
  endtask

  task automatic test_underrun();
    logic [7:0] exp [4] = '{8'hFF, 8'h22, 8'h33, 8'h44};
    clear_logs();
    ack_lat = 40;
    spi_read(8'h03, 24'h000004, 4);
    for (int i = 0; i < 4; i++) begin
      check_cnt++;
      if (rx_buf[i] !== exp[i]) $display("[TB] FAIL underrun_byte%0d: got %02h, expected %02h", i, rx_buf[i], exp[i]);
      else pass_cnt++;
    end
    check_cnt++;
    if (underrun_cnt != 1) $display("[TB] FAIL underrun_pulses: got %0d, expected 1", underrun_cnt);
    else pass_cnt++;
    spi_wait(60);
    ack_lat = 2;
  endtask

  task automatic test_reset_mid_cycle();
    logic [7:0] r;
    ack_lat = 40;
    spi_begin();
    spi_byte(8'h03, r);
    spi_byte(8'h00, r);
    spi_byte(8'h00, r);
    spi_byte(8'h04, r);
    spi_wait(2);
    check_cnt++;
    if (bus.wb_cyc_o !== 1'b1) $display("[TB] FAIL midrst_cyc_before: got %b, expected 1", bus.wb_cyc_o);
    else pass_cnt++;
    wb_rst_i = 1'b1;
    spi_cs   = 1'b1;
    @(negedge wb_clk_i);
    check_cnt++;
    if (bus.wb_cyc_o !== 1'b0) $display("[TB] FAIL midrst_cyc: got %b, expected 0", bus.wb_cyc_o);
    else pass_cnt++;
    check_cnt++;
    if (bus.wb_adr_o !== 24'h0) $display("[TB] FAIL midrst_adr: got %06h, expected 000000", bus.wb_adr_o);
    else pass_cnt++;
    check_cnt++;
    if (spi_miso !== 1'b1) $display("[TB] FAIL midrst_miso: got %b, expected 1", spi_miso);
    else pass_cnt++;
    check_cnt++;
    if (dut.state !== S_IDLE) $display("[TB] FAIL midrst_idle: got state %0d, expected %0d", dut.state, S_IDLE);
    else pass_cnt++;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    spi_wait(10);
    ack_lat = 2;
  endtask

  initial begin
    test_reset();
    test_read_aligned();
    test_read_unaligned();
    test_read_wrap();
    test_ignore_opcodes();
    test_abort_addr();
    test_underrun();
    test_reset_mid_cycle();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
